e_mdu: RTL and testbench
========================

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu/madd/maddu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 E_Start  in  1  qualifies E_MDUOp this cycle.
REQ-006 E_MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; others = none.
REQ-007 E_RS  in  32  operand A (dividend / multiplicand / mthi-mtlo source).
REQ-008 E_RT  in  32  operand B (divisor / multiplier).
REQ-009 E_Busy  out  1  high while an operation is in flight.
REQ-010 E_RDHI  out  32  architectural HI register.
REQ-011 E_RDLO  out  32  architectural LO register.

Function
REQ-012 FSM states IDLE, BUSY; IDLE→BUSY on accepted mult/div-class op; BUSY→IDLE when counter reaches 0.
REQ-013 Op accepted only when E_Start=1, state IDLE and E_Busy=0; E_Start in BUSY is ignored with no state change.
REQ-014 On acceptance at edge t: operands latched, result computed into internal HI'/LO', counter loaded with MULT_CYCLES or DIV_CYCLES.
REQ-015 E_Busy high for exactly N cycles after the accepting edge; HI/LO commit on the edge that drops E_Busy; new values visible the same cycle E_Busy reads 0.
REQ-016 E_RDHI/E_RDLO hold old values throughout BUSY.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-019 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-020 Divisor 0 (div/divu): BUSY for DIV_CYCLES, HI and LO unchanged at commit.
REQ-021 mthi/mtlo: single-cycle, no BUSY; HI (or LO) = E_RS at accepting edge, other register untouched.
REQ-022 Op none or undefined with E_Start=1: no effect.
REQ-023 E_Busy is a registered output; no combinational path from inputs to any output.

Reset
REQ-024 reset=1 at an edge: state IDLE, counter 0, E_Busy=0, E_RDHI=0, E_RDLO=0.
REQ-025 reset during BUSY discards pending result; reset overrides a simultaneous E_Start.

Configuration
REQ-026 Macro MDU_MADD_EN: when defined, madd = {HI,LO} + signed product, maddu = {HI,LO} + unsigned product, mod 2^64, MULT_CYCLES latency, accumulator sampled at acceptance.
REQ-027 Without MDU_MADD_EN: opcodes 7/8 treated as none (no BUSY, no HI/LO change).

Structure
REQ-028 Package mdu_pkg holds opcode constants, default cycle counts, FSM state encoding.
REQ-029 One sub-module e_mdu_ctrl: FSM + down-counter, outputs busy and commit strobe; arithmetic stays in e_mdu.

Verification
REQ-030 mult 0xFFFFFFFF×0x00000002 → busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same → HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div -7/2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 → LO=3, HI=1.
REQ-032 mthi 0x1234 then mtlo 0x5678 back-to-back → HI=0x1234, LO=0x5678, E_Busy never high.
REQ-033 div start, E_Start mult at busy cycle 3 → mult ignored; reset at cycle 6 → E_Busy=0, HI=LO=0 next cycle, no later commit.
REQ-034 divu by 0 with HI=0xA, LO=0xB → busy 10 cycles, HI/LO still 0xA/0xB.
REQ-035 MDU_MADD_EN on: HI=0, LO=0xFFFFFFFF, madd 1×1 → HI=1, LO=0; off: same stimulus → no change, E_Busy 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//   * MDUOp opcode constants (4-bit E_MDUOp encoding)
//   * default busy-cycle counts for the multiply and divide classes
//   * down-counter width and the control FSM state encoding
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Wide enough for any sensible latency parameter (up to 255 cycles).
    localparam int CNT_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl -- sequencing for the multiply/divide unit: IDLE/BUSY FSM plus
// a down-counter. No arithmetic lives here.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start_i      accepted multi-cycle op this cycle (already qualified)
//   load_i       busy-cycle count to load on start
//   busy_o       high while a multi-cycle op is in flight (flop-decoded)
//   commit_o     high during the last busy cycle; the result commits on
//                the edge that ends it, which is also the edge busy drops
//   state_o      current FSM state, exposed for observation
module e_mdu_ctrl
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_i,
    output logic             busy_o,
    output logic             commit_o,
    output mdu_state_e       state_o
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A zero-length load would wrap the counter; treat it as no-op.
                if (start_i && (load_i != '0)) begin
                    state_d = S_BUSY;
                    cnt_d   = load_i;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_IDLE;
                    commit_o = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pure decode of the state flop: no input-to-output path.
    assign busy_o  = (state_q == S_BUSY);
    assign state_o = state_q;

endmodule

// File: rtl/e_mdu.sv
// e_mdu -- E-stage multiply/divide unit with architectural HI/LO registers.
// The result is computed at acceptance into a staging pair and committed
// to HI/LO when the busy period ends, so HI/LO hold old values while busy.
// Handshake: E_Start is the valid; the unit is ready when its FSM is IDLE
// and E_Busy is low. An op transfers on a rising edge where both hold;
// E_Start while not ready is dropped, not queued.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   E_Start, E_MDUOp  op strobe and 4-bit opcode (see mdu_pkg)
//   E_RS, E_RT        operand A (dividend/multiplicand/mthi-mtlo source),
//                     operand B (divisor/multiplier)
//   E_Busy            high while a multi-cycle op is in flight
//   E_RDHI, E_RDLO    architectural HI and LO
// Parameters: MULT_CYCLES (mult/multu/madd/maddu), DIV_CYCLES (div/divu).
// Build option: define MDU_MADD_EN to enable madd/maddu (opcodes 7/8);
// otherwise they behave as no-ops.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_Start,
    input  logic [3:0]  E_MDUOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        E_Busy,
    output logic [31:0] E_RDHI,
    output logic [31:0] E_RDLO
);

    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi_q, res_lo_q, res_hi_d, res_lo_d;
    logic        res_wr_q, res_wr_d;

    logic             accept, long_op, commit;
    logic [CNT_W-1:0] cnt_load;
    mdu_state_e       ctrl_state;

    logic [63:0] prod_s, prod_u;
    logic        div_zero, a_neg, b_neg;
    logic [31:0] divisor, abs_a, abs_b, mag_q, mag_r, sq, sr, uq, ur;

    assign accept = E_Start && (ctrl_state == S_IDLE) && !E_Busy;

    always_comb begin
        prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
        prod_u = {32'h0, E_RS} * {32'h0, E_RT};

        // Substitute 1 for a zero divisor so the dividers never see 0; the
        // result is discarded via res_wr_d anyway.
        div_zero = (E_RT == 32'h0);
        divisor  = div_zero ? 32'd1 : E_RT;
        uq       = E_RS / divisor;
        ur       = E_RS % divisor;

        // Signed division on magnitudes. 0x80000000 / -1 falls out
        // naturally: |a| = 0x80000000, quotient sign positive -> 0x80000000.
        a_neg = E_RS[31];
        b_neg = divisor[31];
        abs_a = a_neg ? (32'h0 - E_RS) : E_RS;
        abs_b = b_neg ? (32'h0 - divisor) : divisor;
        mag_q = abs_a / abs_b;
        mag_r = abs_a % abs_b;
        sq    = (a_neg ^ b_neg) ? (32'h0 - mag_q) : mag_q;
        sr    = a_neg ? (32'h0 - mag_r) : mag_r;

        long_op  = 1'b0;
        cnt_load = '0;
        res_hi_d = hi_q;
        res_lo_d = lo_q;
        res_wr_d = 1'b1;
        case (E_MDUOp)
            OP_MULT: begin
                long_op = 1'b1;
                cnt_load = CNT_W'(MULT_CYCLES);
                {res_hi_d, res_lo_d} = prod_s;
            end
            OP_MULTU: begin
                long_op = 1'b1;
                cnt_load = CNT_W'(MULT_CYCLES);
                {res_hi_d, res_lo_d} = prod_u;
            end
            OP_DIV: begin
                long_op  = 1'b1;
                cnt_load = CNT_W'(DIV_CYCLES);
                res_hi_d = sr;
                res_lo_d = sq;
                res_wr_d = !div_zero;
            end
            OP_DIVU: begin
                long_op  = 1'b1;
                cnt_load = CNT_W'(DIV_CYCLES);
                res_hi_d = ur;
                res_lo_d = uq;
                res_wr_d = !div_zero;
            end
`ifdef MDU_MADD_EN
            // Accumulator is the HI/LO value at acceptance.
            OP_MADD: begin
                long_op = 1'b1;
                cnt_load = CNT_W'(MULT_CYCLES);
                {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s;
            end
            OP_MADDU: begin
                long_op = 1'b1;
                cnt_load = CNT_W'(MULT_CYCLES);
                {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u;
            end
`else
            OP_MADD, OP_MADDU: begin
                // Feature absent: behave exactly like OP_NONE.
            end
`endif
            default: begin
            end
        endcase
    end

    e_mdu_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start_i  (accept && long_op),
        .load_i   (cnt_load),
        .busy_o   (E_Busy),
        .commit_o (commit),
        .state_o  (ctrl_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            if (accept && long_op) begin
                res_hi_q <= res_hi_d;
                res_lo_q <= res_lo_d;
                res_wr_q <= res_wr_d;
            end
            // mthi/mtlo can only be accepted in IDLE, so they never collide
            // with a commit.
            if (accept && (E_MDUOp == OP_MTHI)) hi_q <= E_RS;
            if (accept && (E_MDUOp == OP_MTLO)) lo_q <= E_RS;
            if (commit && res_wr_q) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end
        end
    end

    assign E_RDHI = hi_q;
    assign E_RDLO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        E_Start = 1'b0;
    logic [3:0]  E_MDUOp = 4'd0;
    logic [31:0] E_RS = 32'h0;
    logic [31:0] E_RT = 32'h0;
    logic        E_Busy;
    logic [31:0] E_RDHI, E_RDLO;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    e_mdu dut (
        .clk     (clk),
        .reset   (reset),
        .E_Start (E_Start),
        .E_MDUOp (E_MDUOp),
        .E_RS    (E_RS),
        .E_RT    (E_RT),
        .E_Busy  (E_Busy),
        .E_RDHI  (E_RDHI),
        .E_RDLO  (E_RDLO)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural effect of one accepted op on {HI,LO}, plus its latency.
    task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] hi_in, input logic [31:0] lo_in,
                         output logic [31:0] hi_out, output logic [31:0] lo_out, output int lat);
        longint sa, sb, sq, sr;
        logic [63:0] p;
        hi_out = hi_in;
        lo_out = lo_in;
        lat = 0;
        case (op)
            4'd1: begin lat = MC; p = longint'($signed(rs)) * longint'($signed(rt)); {hi_out, lo_out} = p; end
            4'd2: begin lat = MC; p = {32'h0, rs} * {32'h0, rt}; {hi_out, lo_out} = p; end
            4'd3: begin
                lat = DC;
                if (rt != 0) begin
                    sa = longint'($signed(rs));
                    sb = longint'($signed(rt));
                    sq = sa / sb;
                    sr = sa % sb;
                    lo_out = sq[31:0];
                    hi_out = sr[31:0];
                end
            end
            4'd4: begin
                lat = DC;
                if (rt != 0) begin
                    lo_out = rs / rt;
                    hi_out = rs % rt;
                end
            end
            4'd5: hi_out = rs;
            4'd6: lo_out = rs;
`ifdef MDU_MADD_EN
            4'd7: begin lat = MC; p = longint'($signed(rs)) * longint'($signed(rt)); {hi_out, lo_out} = {hi_in, lo_in} + p; end
            4'd8: begin lat = MC; p = {32'h0, rs} * {32'h0, rt}; {hi_out, lo_out} = {hi_in, lo_in} + p; end
`endif
            default: ;
        endcase
    endtask

    // ---------------- driver ----------------
    // Called at posedge+#1; op is accepted on the next posedge, and each
    // following posedge+#1 is one cycle of the op's lifetime.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] nh, nl;
        logic [63:0] e;
        int lat;
        model(op, rs, rt, m_hi, m_lo, nh, nl, lat);
        exp_q.push_back({nh, nl});
        E_Start = 1'b1; E_MDUOp = op; E_RS = rs; E_RT = rt;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDUOp = 4'd0;
        for (int k = 1; k <= lat; k++) begin
            check($sformatf("busy op%0d c%0d", op, k), 64'(E_Busy), 64'd1);
            check($sformatf("hold op%0d c%0d", op, k), {E_RDHI, E_RDLO}, {m_hi, m_lo});
            @(posedge clk); #1;
        end
        e = exp_q.pop_front();
        check($sformatf("idle op%0d", op), 64'(E_Busy), 64'd0);
        check($sformatf("hilo op%0d", op), {E_RDHI, E_RDLO}, e);
        m_hi = nh;
        m_lo = nl;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rt_r;
        logic [3:0]  op_r;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_busy", 64'(E_Busy), 64'd0);
        check("rst_hi", 64'(E_RDHI), 64'd0);
        check("rst_lo", 64'(E_RDLO), 64'd0);

        // Directed multiply / divide values.
        run_op(4'd1, 32'hFFFF_FFFF, 32'h2);
        check("mult_const", {E_RDHI, E_RDLO}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'h2);
        check("multu_const", {E_RDHI, E_RDLO}, 64'h0000_0001_FFFF_FFFE);
        run_op(4'd3, 32'hFFFF_FFF9, 32'h2);
        check("div_const", {E_RDHI, E_RDLO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd2);
        check("divu_const", {E_RDHI, E_RDLO}, 64'h0000_0001_0000_0003);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {E_RDHI, E_RDLO}, 64'h0000_0000_8000_0000);

        // Back-to-back mthi/mtlo, never busy.
        run_op(4'd5, 32'h1234, 32'h0);
        run_op(4'd6, 32'h5678, 32'h0);
        check("mthilo_const", {E_RDHI, E_RDLO}, 64'h0000_1234_0000_5678);

        // Divide by zero leaves HI/LO alone.
        run_op(4'd5, 32'hA, 32'h0);
        run_op(4'd6, 32'hB, 32'h0);
        run_op(4'd4, 32'd99, 32'd0);
        check("divz_const", {E_RDHI, E_RDLO}, 64'h0000_000A_0000_000B);
        run_op(4'd3, 32'hFFFF_0000, 32'd0);

        // Undefined and none opcodes.
        for (int u = 9; u <= 15; u++) run_op(4'(u), $urandom, $urandom);
        run_op(4'd0, $urandom, $urandom);

        // madd accumulate through 2^32 carry.
        run_op(4'd5, 32'h0, 32'h0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'h0);
        run_op(4'd7, 32'h1, 32'h1);
`ifdef MDU_MADD_EN
        check("madd_const", {E_RDHI, E_RDLO}, 64'h0000_0001_0000_0000);
`else
        check("madd_const", {E_RDHI, E_RDLO}, 64'h0000_0000_FFFF_FFFF);
`endif
        run_op(4'd8, 32'hFFFF_FFFF, 32'h3);

        // Start during busy is ignored; reset mid-busy discards the result.
        run_op(4'd5, 32'h55, 32'h0);
        run_op(4'd6, 32'h66, 32'h0);
        E_Start = 1'b1; E_MDUOp = 4'd3; E_RS = 32'd100; E_RT = 32'd7;
        tick();                                   // busy cycle 1
        E_Start = 1'b0; E_MDUOp = 4'd0;
        check("ign_busy1", 64'(E_Busy), 64'd1);
        tick();                                   // cycle 2
        tick();                                   // cycle 3
        E_Start = 1'b1; E_MDUOp = 4'd1; E_RS = 32'd3; E_RT = 32'd3;
        tick();                                   // cycle 4
        E_Start = 1'b0; E_MDUOp = 4'd0;
        check("ign_busy4", 64'(E_Busy), 64'd1);
        check("ign_hold", {E_RDHI, E_RDLO}, 64'h0000_0055_0000_0066);
        tick();                                   // cycle 5
        tick();                                   // cycle 6
        check("ign_busy6", 64'(E_Busy), 64'd1);
        reset = 1'b1;
        E_Start = 1'b1; E_MDUOp = 4'd5; E_RS = 32'hDEAD;
        tick();
        reset = 1'b0;
        E_Start = 1'b0; E_MDUOp = 4'd0;
        check("mrst_busy", 64'(E_Busy), 64'd0);
        check("mrst_hilo", {E_RDHI, E_RDLO}, 64'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        for (int k = 0; k < DC + 3; k++) begin
            tick();
            check("mrst_nocommit", {31'h0, E_Busy, E_RDHI, E_RDLO}, 96'h0);
        end

        // Randomized ops against the model.
        for (int n = 0; n < 60; n++) begin
            op_r = 4'($urandom_range(0, 15));
            rt_r = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 5) == 0) rt_r = 32'hFFFF_FFFF;
            run_op(op_r, ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, rt_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
